inst_rom_loader: RTL and testbench

Boot-loading instruction memory that sits directly upstream of the `openmips` core. It answers the core's instruction-fetch interface (`rom_ce`/`rom_addr`/`rom_data`) from an internal word array. Before the core runs, the block fills that array from a byte stream (UART receiver) using a length/payload/checksum protocol. The core is held in reset until a load completes with a good checksum.

---
 rtl/inst_rom_loader.sv | 162 ++++++++++++++++
 tb/tb_inst_rom_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: boot-loading instruction ROM for the openmips core.
// A byte stream carries a 16-bit little-endian word count, the payload words
// (little-endian bytes) and an XOR checksum. The core stays in reset until a
// load finishes with a matching checksum. Fetches are answered combinationally
// from the word array in every state.
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        cpu_rst_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  state_t                state;
  // One extra bit so a full-depth load can count past the last index.
  logic [DEPTH_LOG2:0]   wptr;
  logic [1:0]            lane;
  logic [7:0]            csum;
  logic [7:0]            len_lo;
  logic [15:0]           n_words;
  // Bytes 0..2 of the word being assembled; byte 3 arrives with the write.
  logic [23:0]           word_buf;
  logic [31:0]           mem [DEPTH];

  logic                  xfer;
  logic [15:0]           len_full;
  logic                  len_over;
  logic                  last_word;
  logic                  wr_en;
  logic [31:0]           wr_word;
  logic                  addr_in_range;
  logic                  addr_lsb_unused;

  // A restart pulse wins over a byte presented in the same cycle.
  assign xfer      = byte_valid && byte_ready && !load_start;
  assign len_full  = {byte_data, len_lo};
  assign len_over  = 32'(len_full) > 32'(DEPTH);
  assign last_word = (32'(wptr) + 32'd1) == 32'(n_words);
  assign wr_en     = xfer && (state == DATA) && (lane == 2'd3);
  assign wr_word   = {byte_data, word_buf};

  // Stream is accepted only while a load is in progress.
  assign byte_ready = (state == LEN0) || (state == LEN1) ||
                      (state == DATA) || (state == CSUM);

  // Load sequencer: length, payload, checksum, then release or flag the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wptr        <= '0;
      lane        <= '0;
      csum        <= '0;
      len_lo      <= '0;
      n_words     <= '0;
      cpu_rst_o   <= 1'b1;
      load_done_o <= 1'b0;
      load_err_o  <= 1'b0;
    end else if (load_start) begin
      state       <= LEN0;
      wptr        <= '0;
      lane        <= '0;
      csum        <= '0;
      cpu_rst_o   <= 1'b1;
      load_done_o <= 1'b0;
      load_err_o  <= 1'b0;
    end else if (xfer) begin
      case (state)
        LEN0: begin
          len_lo <= byte_data;
          state  <= LEN1;
        end
        LEN1: begin
          n_words <= len_full;
          if (len_over) begin
            state      <= ERR;
            load_err_o <= 1'b1;
          end else if (len_full == 16'd0) begin
            state <= CSUM;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          csum <= csum ^ byte_data;
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            wptr <= wptr + 1'b1;
            if (last_word) begin
              state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (byte_data == csum) begin
            state       <= RUN;
            cpu_rst_o   <= 1'b0;
            load_done_o <= 1'b1;
          end else begin
            state      <= ERR;
            load_err_o <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Collect the low three bytes of each payload word by lane.
  always_ff @(posedge clk) begin
    if (xfer && (state == DATA)) begin
      case (lane)
        2'd0:    word_buf[7:0]   <= byte_data;
        2'd1:    word_buf[15:8]  <= byte_data;
        2'd2:    word_buf[23:16] <= byte_data;
        default: begin
        end
      endcase
    end
  end

  // Word array write; contents survive reset and restarts.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[DEPTH_LOG2-1:0]] <= wr_word;
    end
  end

  // Byte offset within a word does not matter for instruction fetch.
  assign addr_lsb_unused = ^rom_addr_i[1:0];
  assign addr_in_range   = (rom_addr_i[31:DEPTH_LOG2+2] == '0);

  // Zero-latency fetch; disabled or out-of-range reads return zero.
  always_comb begin
    rom_data_o = '0;
    if (rom_ce_i && addr_in_range) begin
      rom_data_o = mem[rom_addr_i[DEPTH_LOG2+1:2]];
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: drives load streams, keeps a reference image of
// the word array, and compares fetches against it through an expected queue.
module tb_inst_rom_loader;

  localparam int DEPTH_LOG2 = 6;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        cpu_rst_o;
  logic        load_done_o;
  logic        load_err_o;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] img       [DEPTH];
  logic [31:0] mem_model [DEPTH];
  logic [31:0] img_save  [DEPTH];
  logic [31:0] exp_q [$];

  inst_rom_loader #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .cpu_rst_o  (cpu_rst_o),
    .load_done_o(load_done_o),
    .load_err_o (load_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one byte and hold it until the DUT takes it at a clock edge.
  task automatic send_byte(input logic [7:0] b, input bit throttle);
    int  waited;
    bit  got;
    if (throttle) begin
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    got        = 1'b0;
    waited     = 0;
    while (!got && waited < 200) begin
      if (byte_ready) got = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_handshake: byte_ready=%b after %0d cycles, required 1", byte_ready, waited);
    end
  endtask

  // Stream a full load of img[0..n-1]; checks status around each phase.
  task automatic run_load(input int n, input bit throttle, input bit corrupt,
                          input bit do_start, input string tag);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] len;
    len = 16'(n);
    cs  = 8'h00;
    if (do_start) begin
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      vectors++;
      if ({cpu_rst_o, byte_ready, load_done_o, load_err_o} !== 4'b1100) begin
        miscompares++;
        $display("FAIL %s_start: status=%b required 1100", tag,
                 {cpu_rst_o, byte_ready, load_done_o, load_err_o});
      end
    end
    send_byte(len[7:0], throttle);
    send_byte(len[15:8], throttle);
    if (n > DEPTH) begin
      byte_valid = 1'b0;
      vectors++;
      if ({cpu_rst_o, byte_ready, load_done_o, load_err_o} !== 4'b1001) begin
        miscompares++;
        $display("FAIL %s_oversize: status=%b required 1001", tag,
                 {cpu_rst_o, byte_ready, load_done_o, load_err_o});
      end
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = img[i][8*k +: 8];
        cs = cs ^ b;
        send_byte(b, throttle);
      end
      mem_model[i] = img[i];
    end
    vectors++;
    if ({cpu_rst_o, byte_ready, load_done_o, load_err_o} !== 4'b1100) begin
      miscompares++;
      $display("FAIL %s_csum_wait: status=%b required 1100", tag,
               {cpu_rst_o, byte_ready, load_done_o, load_err_o});
    end
    send_byte(corrupt ? (cs ^ 8'h01) : cs, throttle);
    byte_valid = 1'b0;
    vectors++;
    if (!corrupt) begin
      if ({cpu_rst_o, byte_ready, load_done_o, load_err_o} !== 4'b0010) begin
        miscompares++;
        $display("FAIL %s_run: status=%b required 0010", tag,
                 {cpu_rst_o, byte_ready, load_done_o, load_err_o});
      end
    end else begin
      if ({cpu_rst_o, byte_ready, load_done_o, load_err_o} !== 4'b1001) begin
        miscompares++;
        $display("FAIL %s_err: status=%b required 1001", tag,
                 {cpu_rst_o, byte_ready, load_done_o, load_err_o});
      end
    end
  endtask

  // Single fetch through the expected queue.
  task automatic fetch_check(input logic ce, input logic [31:0] addr,
                             input logic [31:0] expv, input string name);
    logic [31:0] want;
    exp_q.push_back(expv);
    rom_ce_i   = ce;
    rom_addr_i = addr;
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (rom_data_o !== want) begin
      miscompares++;
      $display("FAIL %s: addr=%h rom_data_o=%h required %h", name, addr, rom_data_o, want);
    end
  endtask

  // Queue the reference image for words 0..n-1, then fetch and compare each.
  task automatic check_image(input int n, input string name);
    logic [31:0] want;
    for (int i = 0; i < n; i++) exp_q.push_back(mem_model[i]);
    rom_ce_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      rom_addr_i = 32'(i) << 2;
      #1;
      want = exp_q.pop_front();
      vectors++;
      if (rom_data_o !== want) begin
        miscompares++;
        $display("FAIL %s word %0d: rom_data_o=%h required %h", name, i, rom_data_o, want);
      end
    end
  endtask

  task automatic test_reset;
    vectors++;
    if ({cpu_rst_o, byte_ready, load_done_o, load_err_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_status: status=%b required 1000",
               {cpu_rst_o, byte_ready, load_done_o, load_err_o});
    end
    fetch_check(1'b0, 32'h0, 32'h0, "reset_ce_off");
  endtask

  task automatic test_good_load;
    img[0] = 32'h3402_2001;
    img[1] = 32'h0000_0000;
    run_load(2, 1'b0, 1'b0, 1'b1, "good");
    fetch_check(1'b1, 32'h0, 32'h3402_2001, "good_addr0");
    fetch_check(1'b1, 32'h5, 32'h0000_0000, "good_addr5");
    fetch_check(1'b0, 32'h0, 32'h0000_0000, "good_ce_off");
  endtask

  task automatic test_bad_csum;
    run_load(2, 1'b0, 1'b1, 1'b1, "badcs");
    run_load(2, 1'b0, 1'b0, 1'b1, "badcs_retry");
    check_image(2, "badcs_image");
  endtask

  task automatic test_oversize_empty;
    run_load(DEPTH + 1, 1'b0, 1'b0, 1'b1, "oversize");
    run_load(0, 1'b0, 1'b0, 1'b1, "empty");
    check_image(2, "empty_image");
  endtask

  task automatic test_throttled;
    for (int i = 0; i < 8; i++) begin
      img[i]      = $urandom;
      img_save[i] = img[i];
    end
    run_load(8, 1'b0, 1'b0, 1'b1, "full_a");
    check_image(8, "full_a_image");
    for (int i = 0; i < 8; i++) img[i] = ~img_save[i];
    run_load(8, 1'b0, 1'b0, 1'b1, "full_b");
    check_image(8, "full_b_image");
    for (int i = 0; i < 8; i++) img[i] = img_save[i];
    run_load(8, 1'b1, 1'b0, 1'b1, "throttled_a");
    check_image(8, "throttled_image");
  endtask

  task automatic test_abort;
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = 32'h1122_3344;
    w1 = 32'h5566_7788;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 1'b0);
    mem_model[0] = w0;
    for (int k = 0; k < 3; k++) send_byte(w1[8*k +: 8], 1'b0);
    // Restart together with a byte that would have completed word 1.
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    @(posedge clk); #1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    vectors++;
    if ({cpu_rst_o, byte_ready, load_done_o, load_err_o} !== 4'b1100) begin
      miscompares++;
      $display("FAIL abort_restart: status=%b required 1100",
               {cpu_rst_o, byte_ready, load_done_o, load_err_o});
    end
    check_image(2, "abort_image");
    img[0] = 32'hCAFE_0001;
    run_load(1, 1'b0, 1'b0, 1'b0, "after_abort");
    check_image(2, "after_abort_image");
  endtask

  task automatic test_fetch_bounds;
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    img[DEPTH-1] = 32'hDEAD_BEEF;
    run_load(DEPTH, 1'b0, 1'b0, 1'b1, "fullmem");
    fetch_check(1'b1, 32'(4 * DEPTH), 32'h0, "bound_at_depth");
    fetch_check(1'b1, 32'(4 * DEPTH - 4), 32'hDEAD_BEEF, "bound_last_word");
    fetch_check(1'b1, 32'(4 * DEPTH - 1), 32'hDEAD_BEEF, "bound_last_lsb");
    fetch_check(1'b1, 32'h8000_0000, 32'h0, "bound_high_addr");
    check_image(DEPTH, "fullmem_image");
  endtask

  task automatic test_reset_mid;
    rst = 1'b0;
    #2;
    test_reset();
    fetch_check(1'b1, 32'(4 * DEPTH - 4), 32'hDEAD_BEEF, "reset_mem_kept");
    #3;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cpu_rst_o, byte_ready, load_done_o, load_err_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL post_reset_hold: status=%b required 1000",
               {cpu_rst_o, byte_ready, load_done_o, load_err_o});
    end
  endtask

  initial begin
    rst        = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    rom_ce_i   = 1'b0;
    rom_addr_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_good_load();
    test_bad_csum();
    test_oversize_empty();
    test_throttled();
    test_abort();
    test_fetch_bounds();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
